mrv32_lsu_sb: RTL and testbench

Second-generation MRV32 load/store unit for the MEM stage. It takes the ALU effective address, formats SB/SH/SW and LB/LH/LW/LBU/LHU, and drives memory Port B with a ready/valid handshake. Over the first LSU it adds four things: a parametrised RAM window, a posted store buffer of SB_DEPTH entries, Port B backpressure, and precise fault reporting (misaligned / access) using RISC-V mcause codes instead of silently ignoring bad accesses.

---
 rtl/mrv32_lsu_sb_if.sv | 26 ++
 rtl/mrv32_lsu_sb.sv | 251 +++++++++++++++++++++++++
 tb/tb_mrv32_lsu_sb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrv32_lsu_sb_if.sv
// Port B memory bus between the load/store unit (master) and RAM (slave).
interface mrv32_lsu_sb_if #(
    parameter int ADDR_WIDTH = 16
);
    // Handshake: a request transfers on any cycle where b_valid && b_ready.
    // While b_valid=1 && !b_ready the master holds b_addr/b_wdata/b_wstrb
    // stable. b_wstrb==0 marks a read; its word returns on b_rdata with
    // b_rvalid at least one cycle after the accepting cycle.
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [31:0]           b_wdata;
    logic [3:0]            b_wstrb;
    logic [31:0]           b_rdata;
    logic                  b_rvalid;

    modport master (
        output b_valid, b_addr, b_wdata, b_wstrb,
        input  b_ready, b_rdata, b_rvalid
    );

    modport slave (
        input  b_valid, b_addr, b_wdata, b_wstrb,
        output b_ready, b_rdata, b_rvalid
    );
endinterface

// File: rtl/mrv32_lsu_sb.sv
// MRV32 MEM-stage load/store unit with a posted store buffer, Port B
// backpressure and precise misaligned/access fault reporting.
module mrv32_lsu_sb #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter int          RAM_BYTES  = 65536,
    parameter int          SB_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [3:0]  mem_wstrb,
    input  logic [2:0]  load_funct3,
    input  logic [31:0] eff_addr,
    input  logic [31:0] store_data,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        lsu_fault,
    output logic [3:0]  fault_cause,
    output logic [31:0] fault_addr,
    output logic        sb_empty,
    output logic [1:0]  dbg_state,
    mrv32_lsu_sb_if.master bus
);
    localparam logic [3:0]  WSTRB_NONE = 4'b0000;
    localparam logic [3:0]  WSTRB_B    = 4'b0001;
    localparam logic [3:0]  WSTRB_H    = 4'b0011;
    localparam logic [3:0]  WSTRB_W    = 4'b1111;
    localparam logic [2:0]  F3_LB      = 3'b000;
    localparam logic [2:0]  F3_LH      = 3'b001;
    localparam logic [2:0]  F3_LW      = 3'b010;
    localparam logic [2:0]  F3_LBU     = 3'b100;
    localparam logic [2:0]  F3_LHU     = 3'b101;
    localparam int          CW         = $clog2(SB_DEPTH);
    localparam logic [32:0] RAM_LIMIT  = 33'(RAM_BYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        LD_REQ  = 2'd2,
        LD_WAIT = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Store buffer: circular FIFO of {b_addr, wdata, wstrb}.
    logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
    logic [31:0]           sb_data [SB_DEPTH];
    logic [3:0]            sb_strb [SB_DEPTH];
    logic [CW-1:0]         wr_ptr, rd_ptr;
    logic [CW:0]           count;

    // Latched load context for LD_REQ/LD_WAIT.
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [1:0]            ld_off;
    logic [2:0]            ld_f3;

    logic                  hit, illegal, misal, fault;
    logic [3:0]            cause;
    logic [31:0]           st_wdata;
    logic [3:0]            st_wstrb;
    logic [ADDR_WIDTH-1:0] req_baddr;
    logic [32:0]           rel_addr;
    logic                  drain, pop, push;
    logic                  done_d, fault_d, zero_ld, ld_start, ld_finish;
    logic [3:0]            cause_d;
    logic [31:0]           ld_shift, ld_result;

    assign sb_empty  = (count == '0);
    assign dbg_state = state;
    // Low bits of (eff_addr - RAM_BASE) depend only on the low bits.
    assign req_baddr = eff_addr[ADDR_WIDTH-1:0] - RAM_BASE[ADDR_WIDTH-1:0];
    assign rel_addr  = {1'b0, eff_addr} - {1'b0, RAM_BASE};

    // Request decode: legality, alignment, window hit and store lane formatting.
    always_comb begin
        hit      = ({1'b0, eff_addr} >= {1'b0, RAM_BASE}) && (rel_addr < RAM_LIMIT);
        illegal  = (mem_ren == mem_wen);
        misal    = 1'b0;
        st_wdata = store_data;
        st_wstrb = WSTRB_W;
        if (mem_ren) begin
            case (load_funct3)
                F3_LB, F3_LBU: misal = 1'b0;
                F3_LH, F3_LHU: misal = eff_addr[0];
                F3_LW:         misal = |eff_addr[1:0];
                default:       illegal = 1'b1;
            endcase
        end
        if (mem_wen) begin
            case (mem_wstrb)
                WSTRB_B: begin
                    st_wdata = 32'(store_data[7:0]) << {eff_addr[1:0], 3'b000};
                    st_wstrb = WSTRB_B << eff_addr[1:0];
                end
                WSTRB_H: begin
                    misal    = eff_addr[0];
                    st_wdata = eff_addr[1] ? {store_data[15:0], 16'h0000}
                                           : {16'h0000, store_data[15:0]};
                    st_wstrb = eff_addr[1] ? 4'b1100 : 4'b0011;
                end
                WSTRB_W: misal = |eff_addr[1:0];
                default: illegal = 1'b1;
            endcase
        end
        // Misaligned takes priority over an out-of-window access.
        fault = !illegal && (misal || !hit);
        cause = misal ? (mem_ren ? 4'd4 : 4'd6) : (mem_ren ? 4'd5 : 4'd7);
    end

    // Drain the buffer head whenever no load owns Port B.
    assign drain = (count != '0) && (state != LD_REQ) && (state != LD_WAIT);
    assign pop   = drain && bus.b_ready;

    // Next state and per-cycle control; the full check uses count's MSB since depth is a power of two.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        cause_d   = 4'd0;
        zero_ld   = 1'b0;
        ld_start  = 1'b0;
        ld_finish = 1'b0;
        case (state)
            IDLE: begin
                // lsu_done high means the requester has not yet dropped the finished request.
                if (mem_valid && !lsu_done) state_nxt = EXEC;
            end
            EXEC: begin
                if (illegal || fault) begin
                    done_d    = 1'b1;
                    fault_d   = fault;
                    cause_d   = fault ? cause : 4'd0;
                    zero_ld   = illegal || mem_ren;
                    state_nxt = IDLE;
                end else if (mem_wen) begin
                    if (!count[CW] || pop) begin
                        push      = 1'b1;
                        done_d    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (count == '0) begin
                    ld_start  = 1'b1;
                    state_nxt = LD_REQ;
                end
            end
            LD_REQ: begin
                if (bus.b_ready) state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (bus.b_rvalid) begin
                    ld_finish = 1'b1;
                    done_d    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Port B mux: buffered store head or the pending load read.
    always_comb begin
        bus.b_valid = 1'b0;
        bus.b_addr  = ld_addr;
        bus.b_wdata = 32'h0;
        bus.b_wstrb = WSTRB_NONE;
        if (drain) begin
            bus.b_valid = 1'b1;
            bus.b_addr  = sb_addr[rd_ptr];
            bus.b_wdata = sb_data[rd_ptr];
            bus.b_wstrb = sb_strb[rd_ptr];
        end else if (state == LD_REQ) begin
            bus.b_valid = 1'b1;
        end
    end

    // Load extraction: select lane at the latched offset, then extend per funct3.
    always_comb begin
        ld_shift = bus.b_rdata >> {ld_off, 3'b000};
        case (ld_f3)
            F3_LB:   ld_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_LBU:  ld_result = {24'h0, ld_shift[7:0]};
            F3_LH:   ld_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_LHU:  ld_result = {16'h0, ld_shift[15:0]};
            default: ld_result = ld_shift;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Buffer pointers and occupancy; push+pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Buffer storage; contents are meaningless until pushed so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= req_baddr;
            sb_data[wr_ptr] <= st_wdata;
            sb_strb[wr_ptr] <= st_wstrb;
        end
    end

    // Load context captured when the read is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_addr <= '0;
            ld_off  <= 2'd0;
            ld_f3   <= 3'd0;
        end else if (ld_start) begin
            ld_addr <= req_baddr;
            ld_off  <= eff_addr[1:0];
            ld_f3   <= load_funct3;
        end
    end

    // Registered completion, fault reporting and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_done    <= 1'b0;
            lsu_fault   <= 1'b0;
            fault_cause <= 4'd0;
            fault_addr  <= 32'h0;
            load_data   <= 32'h0;
        end else begin
            lsu_done    <= done_d;
            lsu_fault   <= fault_d;
            fault_cause <= cause_d;
            fault_addr  <= fault_d ? eff_addr : 32'h0;
            if (ld_finish)    load_data <= ld_result;
            else if (zero_ld) load_data <= 32'h0;
        end
    end
endmodule

// File: tb/tb_mrv32_lsu_sb.sv
// Self-checking bench for mrv32_lsu_sb: vector table plus backpressure and reset sequences.
module tb_mrv32_lsu_sb;
    localparam int AW = 16;
    localparam int W  = AW + 36;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [2:0]  load_funct3 = 3'h0;
    logic [31:0] eff_addr = 32'h0, store_data = 32'h0;
    logic        lsu_done, lsu_fault, sb_empty;
    logic [31:0] load_data, fault_addr;
    logic [3:0]  fault_cause;
    logic [1:0]  dbg_state;

    mrv32_lsu_sb_if #(.ADDR_WIDTH(AW)) bus ();

    mrv32_lsu_sb #(
        .ADDR_WIDTH(AW), .RAM_BASE(32'h0), .RAM_BYTES(65536), .SB_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .load_funct3(load_funct3),
        .eff_addr(eff_addr), .store_data(store_data), .lsu_done(lsu_done),
        .load_data(load_data), .lsu_fault(lsu_fault), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .sb_empty(sb_empty), .dbg_state(dbg_state),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int bv_cycles = 0;
    int viol      = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  ram [int];

    typedef struct {
        logic        st;
        logic [3:0]  strb;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        flt;
        logic [3:0]  cause;
        logic        chk_ld;
        logic [31:0] ld;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t vecs[22];

    // Clock and watchdog.
    initial forever #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Port B slave: samples the handshake mid-cycle, acts just after the edge.
    initial begin
        logic          acc;
        logic [AW-1:0] a;
        logic [31:0]   wd, tmp;
        logic [3:0]    ws;
        bus.b_ready  = 1'b0;
        bus.b_rvalid = 1'b0;
        bus.b_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            acc = bus.b_valid && bus.b_ready && !rst;
            a   = bus.b_addr;
            wd  = bus.b_wdata;
            ws  = bus.b_wstrb;
            @(posedge clk);
            #1;
            bus.b_rvalid = 1'b0;
            if (acc && ws != 4'h0) begin
                tmp = ram.exists(int'(a >> 2)) ? ram[int'(a >> 2)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) tmp[8*b +: 8] = wd[8*b +: 8];
                ram[int'(a >> 2)] = tmp;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got %0h expected none", {a, wd, ws});
                end else begin
                    check("sb_write", 64'({a, wd, ws}), 64'(exp_q.pop_front()));
                end
            end else if (acc) begin
                bus.b_rdata  = ram.exists(int'(a >> 2)) ? ram[int'(a >> 2)] : 32'h0;
                bus.b_rvalid = 1'b1;
            end
        end
    end

    // Protocol monitor: Port B hold stability and single-cycle lsu_done.
    initial begin
        logic          prev_hold = 1'b0, prev_done = 1'b0;
        logic [W-1:0]  prev_f = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.b_valid) bv_cycles++;
                if (lsu_done && prev_done) viol++;
                if (prev_hold && bus.b_valid && {bus.b_addr, bus.b_wdata, bus.b_wstrb} !== prev_f) viol++;
                prev_hold = bus.b_valid && !bus.b_ready;
                prev_f    = {bus.b_addr, bus.b_wdata, bus.b_wstrb};
                prev_done = lsu_done;
            end
        end
    end

    // Driver tasks.
    task automatic drive_req(input logic st, input logic [3:0] strb, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_valid = 1'b1; mem_ren = !st; mem_wen = st;
        mem_wstrb = strb; load_funct3 = f3; eff_addr = a; store_data = d;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (lsu_done) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_done"},   64'(lsu_done), 64'd0);
        check({tag, "_fault"},  64'(lsu_fault), 64'd0);
        check({tag, "_cause"},  64'(fault_cause), 64'd0);
        check({tag, "_faddr"},  64'(fault_addr), 64'd0);
        check({tag, "_ldata"},  64'(load_data), 64'd0);
        check({tag, "_bvalid"}, 64'(bus.b_valid), 64'd0);
        check({tag, "_bwstrb"}, 64'(bus.b_wstrb), 64'd0);
        check({tag, "_sbempty"}, 64'(sb_empty), 64'd1);
        check({tag, "_state"},  64'(dbg_state), 64'd0);
    endtask

    initial begin
        int   bv0;
        logic stall_done;

        //             st    strb   f3      addr          data          flt  cause ck  ld            wr   wdata         wstrb
        vecs[0]  = '{1'b1, 4'hF, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 4'hF};
        vecs[1]  = '{1'b0, 4'h0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 4'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,       4'h0};
        vecs[2]  = '{1'b0, 4'h0, 3'd1, 32'h0000_0101, 32'h0,         1'b1, 4'd4, 1'b1, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[3]  = '{1'b1, 4'h1, 3'd0, 32'h0000_0203, 32'h0000_0080, 1'b0, 4'd0, 1'b0, 32'h0,        1'b1, 32'h8000_0000, 4'h8};
        vecs[4]  = '{1'b0, 4'h0, 3'd0, 32'h0000_0203, 32'h0,         1'b0, 4'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 32'h0,       4'h0};
        vecs[5]  = '{1'b0, 4'h0, 3'd4, 32'h0000_0203, 32'h0,         1'b0, 4'd0, 1'b1, 32'h0000_0080, 1'b0, 32'h0,       4'h0};
        vecs[6]  = '{1'b1, 4'h3, 3'd0, 32'h0000_0302, 32'h0000_A5C3, 1'b0, 4'd0, 1'b0, 32'h0,        1'b1, 32'hA5C3_0000, 4'hC};
        vecs[7]  = '{1'b1, 4'h3, 3'd0, 32'h0000_0300, 32'hFFFF_1234, 1'b0, 4'd0, 1'b0, 32'h0,        1'b1, 32'h0000_1234, 4'h3};
        vecs[8]  = '{1'b0, 4'h0, 3'd1, 32'h0000_0302, 32'h0,         1'b0, 4'd0, 1'b1, 32'hFFFF_A5C3, 1'b0, 32'h0,       4'h0};
        vecs[9]  = '{1'b0, 4'h0, 3'd5, 32'h0000_0302, 32'h0,         1'b0, 4'd0, 1'b1, 32'h0000_A5C3, 1'b0, 32'h0,       4'h0};
        vecs[10] = '{1'b0, 4'h0, 3'd2, 32'h0000_0300, 32'h0,         1'b0, 4'd0, 1'b1, 32'hA5C3_1234, 1'b0, 32'h0,       4'h0};
        vecs[11] = '{1'b0, 4'h0, 3'd3, 32'h0000_0300, 32'h0,         1'b0, 4'd0, 1'b1, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[12] = '{1'b1, 4'h5, 3'd0, 32'h0000_0700, 32'h1111_1111, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[13] = '{1'b1, 4'hF, 3'd0, 32'h0001_0000, 32'h1234_5678, 1'b1, 4'd7, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[14] = '{1'b1, 4'hF, 3'd0, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 4'd7, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[15] = '{1'b1, 4'hF, 3'd0, 32'h0000_0102, 32'h1234_5678, 1'b1, 4'd6, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[16] = '{1'b0, 4'h0, 3'd2, 32'h0001_0000, 32'h0,         1'b1, 4'd5, 1'b1, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[17] = '{1'b0, 4'h0, 3'd2, 32'h0001_0002, 32'h0,         1'b1, 4'd4, 1'b1, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[18] = '{1'b1, 4'hF, 3'd0, 32'h0001_0001, 32'h1234_5678, 1'b1, 4'd6, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0};
        vecs[19] = '{1'b1, 4'h1, 3'd0, 32'h0000_0000, 32'hABCD_EF7F, 1'b0, 4'd0, 1'b0, 32'h0,        1'b1, 32'h0000_007F, 4'h1};
        vecs[20] = '{1'b0, 4'h0, 3'd0, 32'h0000_0000, 32'h0,         1'b0, 4'd0, 1'b1, 32'h0000_007F, 1'b0, 32'h0,       4'h0};
        vecs[21] = '{1'b0, 4'h0, 3'd5, 32'h0000_0001, 32'h0,         1'b1, 4'd4, 1'b1, 32'h0,        1'b0, 32'h0,        4'h0};

        // Reset block.
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Table-driven vectors with Port B always ready.
        bus.b_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) exp_q.push_back({vecs[i].addr[AW-1:0], vecs[i].wdata, vecs[i].wstrb});
            bv0 = bv_cycles;
            drive_req(vecs[i].st, vecs[i].strb, vecs[i].f3, vecs[i].addr, vecs[i].data);
            wait_done($sformatf("v%0d_done", i), 60);
            check($sformatf("v%0d_fault", i), 64'(lsu_fault), 64'(vecs[i].flt));
            check($sformatf("v%0d_cause", i), 64'(fault_cause), 64'(vecs[i].cause));
            check($sformatf("v%0d_faddr", i), 64'(fault_addr), vecs[i].flt ? 64'(vecs[i].addr) : 64'd0);
            if (vecs[i].chk_ld) check($sformatf("v%0d_ldata", i), 64'(load_data), 64'(vecs[i].ld));
            if (vecs[i].flt) check($sformatf("v%0d_no_portb", i), 64'(bv_cycles - bv0), 64'd0);
            release_req();
        end

        // Backpressure: four stores fill the buffer, the fifth stalls in EXEC.
        @(posedge clk);
        #1 bus.b_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            exp_q.push_back({16'h0400 + 16'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF});
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 4'hF, 3'd0, 32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            wait_done($sformatf("bp_st%0d_done", i), 20);
            release_req();
        end
        @(negedge clk);
        check("bp_sb_not_empty", 64'(sb_empty), 64'd0);
        check("bp_head_addr", 64'(bus.b_addr), 64'h400);
        drive_req(1'b1, 4'hF, 3'd0, 32'h410, 32'hC0DE_0004);
        stall_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (lsu_done) stall_done = 1'b1;
        end
        check("bp_stall_no_done", 64'(stall_done), 64'd0);
        check("bp_stall_state", 64'(dbg_state), 64'd1);
        @(posedge clk);
        #1 bus.b_ready = 1'b1;
        wait_done("bp_st4_done", 20);
        release_req();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("bp_drained_empty", 64'(sb_empty), 64'd1);
        check("bp_exp_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset with three stores buffered under backpressure.
        exp_q.push_back({16'h0300, 32'hA5C3_1234, 4'hF});
        drive_req(1'b1, 4'hF, 3'd0, 32'h300, 32'hA5C3_1234);
        wait_done("rs_pre_st_done", 20);
        release_req();
        drive_req(1'b0, 4'h0, 3'd2, 32'h300, 32'h0);
        wait_done("rs_pre_ld_done", 40);
        check("rs_pre_ldata", 64'(load_data), 64'hA5C3_1234);
        release_req();
        @(posedge clk);
        #1 bus.b_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 4'hF, 3'd0, 32'h500 + 32'(4 * i), 32'h5A5A_0000 + 32'(i));
            wait_done($sformatf("rs_st%0d_done", i), 20);
            release_req();
        end
        @(negedge clk);
        check("rs_bvalid_before", 64'(bus.b_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_vals("rs_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.b_ready = 1'b1;
        bv0 = bv_cycles;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rs_no_drain_after", 64'(bv_cycles - bv0), 64'd0);
        check_reset_vals("rs_after");

        // Normal traffic after reset.
        exp_q.push_back({16'h0600, 32'h1357_9BDF, 4'hF});
        drive_req(1'b1, 4'hF, 3'd0, 32'h600, 32'h1357_9BDF);
        wait_done("post_st_done", 20);
        release_req();
        drive_req(1'b0, 4'h0, 3'd2, 32'h600, 32'h0);
        wait_done("post_ld_done", 40);
        check("post_ldata", 64'(load_data), 64'h1357_9BDF);
        release_req();

        // Final report.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("protocol_violations", 64'(viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
